// File: rtl/write_register.sv
// write_register: parameterised storage register with write enable.
//
// Captures `data` on a rising edge of `clk` while `write` is high and holds
// its value otherwise. Alongside the stored word it provides a sticky
// first-write flag and a one-cycle strobe following every write edge. Every
// output comes straight from a flop, so `data` and `write` have no
// combinational path to any output.
//
// Parameters:
//   WIDTH        data width in bits (1..64), default 32
//   RESET_VALUE  value loaded into q on reset, default all zeros
//
// Ports:
//   clk         in   rising-edge clock
//   data        in   [WIDTH] write data
//   write       in   write enable, sampled on the rising edge
//   q           out  [WIDTH] stored value
//   rst_n       in   asynchronous active-low reset, dominant over writes
//   q_valid     out  high once at least one write has completed since reset
//   updated     out  one-cycle pulse in the cycle after each write edge
//   parity_out  out  even parity (XOR-reduction) of q; present only when
//                    WRITE_REGISTER_PARITY_EN is defined
//
// Port order keeps positional instantiations of the original four ports
// (clk, data, write, q) working.

module write_register #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] data,
  input  logic             write,
  output logic [WIDTH-1:0] q,
  input  logic             rst_n,
  output logic             q_valid,
  output logic             updated
`ifdef WRITE_REGISTER_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  // Stored word; only a write edge changes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (write) begin
      q <= data;
    end
  end

  // Sticky valid flag: set by the first write, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
    end else if (write) begin
      q_valid <= 1'b1;
    end
  end

  // Update strobe: follows write by one cycle, so back-to-back writes hold it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      updated <= 1'b0;
    end else begin
      updated <= write;
    end
  end

`ifdef WRITE_REGISTER_PARITY_EN
  // Parity computed from the incoming word so it changes on the same edge as q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_out <= ^RESET_VALUE;
    end else if (write) begin
      parity_out <= ^data;
    end
  end
`endif

endmodule

// File: tb/tb_write_register.sv
// Bench for write_register: directed scenarios plus a randomized run, each
// checked against a behavioural model of the stored word, valid flag, strobe
// and (when enabled) parity.

module tb_write_register;

  localparam int unsigned W = 32;

  logic         clk;
  logic [W-1:0] data;
  logic         write;
  logic [W-1:0] q;
  logic         rst_n;
  logic         q_valid;
  logic         updated;
`ifdef WRITE_REGISTER_PARITY_EN
  logic         parity_out;
`endif

  write_register dut (
    .clk        (clk),
    .data       (data),
    .write      (write),
    .q          (q),
    .rst_n      (rst_n),
    .q_valid    (q_valid),
    .updated    (updated)
`ifdef WRITE_REGISTER_PARITY_EN
    ,
    .parity_out (parity_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] exp_q;
  logic         exp_valid;
  logic         exp_upd;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic model_reset();
    exp_q     = '0;
    exp_valid = 1'b0;
    exp_upd   = 1'b0;
  endtask

  // Drive one cycle of stimulus from a negedge, advance the model at the
  // posedge, and return at the following negedge for sampling.
  task automatic step(input logic w, input logic [W-1:0] d);
    write = w;
    data  = d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (w) begin
      exp_q     = d;
      exp_valid = 1'b1;
      exp_upd   = 1'b1;
    end else begin
      exp_upd = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    write = 1'b1;
    data  = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (q !== 32'h0000_0000) $display("FAIL reset_q got %h want %h", q, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (q_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", q_valid);
    else pass_cnt++;
    total_cnt++;
    if (updated !== 1'b0) $display("FAIL reset_updated got %b want 0", updated);
    else pass_cnt++;
`ifdef WRITE_REGISTER_PARITY_EN
    total_cnt++;
    if (parity_out !== 1'b0) $display("FAIL reset_parity got %b want 0", parity_out);
    else pass_cnt++;
`endif
    write = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_hold();
    step(1'b0, 32'h0000_0001);
    total_cnt++;
    if (q !== 32'h0000_0000) $display("FAIL hold_q got %h want %h", q, 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (updated !== 1'b0) $display("FAIL hold_updated got %b want 0", updated);
    else pass_cnt++;
    total_cnt++;
    if (q_valid !== 1'b0) $display("FAIL hold_valid got %b want 0", q_valid);
    else pass_cnt++;
  endtask

  task automatic test_write();
    step(1'b1, 32'h0000_0002);
    total_cnt++;
    if (q !== 32'h0000_0002) $display("FAIL write_q got %h want %h", q, 32'h2);
    else pass_cnt++;
    total_cnt++;
    if (q_valid !== 1'b1) $display("FAIL write_valid got %b want 1", q_valid);
    else pass_cnt++;
    total_cnt++;
    if (updated !== 1'b1) $display("FAIL write_updated got %b want 1", updated);
    else pass_cnt++;
  endtask

  task automatic test_hold_after_write();
    step(1'b0, 32'h0000_0003);
    total_cnt++;
    if (q !== 32'h0000_0002) $display("FAIL hold2_q got %h want %h", q, 32'h2);
    else pass_cnt++;
    total_cnt++;
    if (updated !== 1'b0) $display("FAIL hold2_updated got %b want 0", updated);
    else pass_cnt++;
    total_cnt++;
    if (q_valid !== 1'b1) $display("FAIL hold2_valid got %b want 1", q_valid);
    else pass_cnt++;
    // Input changes between edges must not reach q.
    #2 data = 32'h1234_5678;
    write = 1'b1;
    #1 write = 1'b0;
    #1;
    total_cnt++;
    if (q !== 32'h0000_0002) $display("FAIL midcycle_q got %h want %h", q, 32'h2);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'hFFFF_FFFF);
    total_cnt++;
    if (q !== 32'hFFFF_FFFF || updated !== 1'b1)
      $display("FAIL b2b_first got q=%h upd=%b want q=%h upd=1", q, updated, 32'hFFFF_FFFF);
    else pass_cnt++;
    step(1'b1, 32'hA5A5_A5A5);
    total_cnt++;
    if (q !== 32'hA5A5_A5A5 || updated !== 1'b1)
      $display("FAIL b2b_second got q=%h upd=%b want q=%h upd=1", q, updated, 32'hA5A5_A5A5);
    else pass_cnt++;
    step(1'b0, 32'h0);
    total_cnt++;
    if (q !== 32'hA5A5_A5A5 || updated !== 1'b0)
      $display("FAIL b2b_after got q=%h upd=%b want q=%h upd=0", q, updated, 32'hA5A5_A5A5);
    else pass_cnt++;
    // Rewriting the stored value is still a write.
    step(1'b1, 32'hA5A5_A5A5);
    total_cnt++;
    if (updated !== 1'b1) $display("FAIL same_value_updated got %b want 1", updated);
    else pass_cnt++;
  endtask

  task automatic test_parity();
`ifdef WRITE_REGISTER_PARITY_EN
    step(1'b1, 32'h0000_0007);
    total_cnt++;
    if (parity_out !== 1'b1) $display("FAIL parity_7 got %b want 1", parity_out);
    else pass_cnt++;
    step(1'b1, 32'h0000_0003);
    total_cnt++;
    if (parity_out !== 1'b0) $display("FAIL parity_3 got %b want 0", parity_out);
    else pass_cnt++;
`endif
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d;
    d = $urandom;
    step(1'b1, d);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++;
    if (q !== 32'h0 || q_valid !== 1'b0 || updated !== 1'b0)
      $display("FAIL async_reset got q=%h v=%b upd=%b want 0/0/0", q, q_valid, updated);
    else pass_cnt++;
    // Write held during reset across an edge: reset wins.
    @(negedge clk);
    step(1'b1, 32'hCAFE_F00D);
    total_cnt++;
    if (q !== 32'h0 || q_valid !== 1'b0 || updated !== 1'b0)
      $display("FAIL reset_wins got q=%h v=%b upd=%b want 0/0/0", q, q_valid, updated);
    else pass_cnt++;
    // Release away from the edge; the first edge after release captures.
    rst_n = 1'b1;
    d = $urandom;
    step(1'b1, d);
    total_cnt++;
    if (q !== d || q_valid !== 1'b1 || updated !== 1'b1)
      $display("FAIL first_after_release got q=%h v=%b upd=%b want q=%h 1/1", q, q_valid, updated, d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic         w;
    logic [W-1:0] d;
    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      step(w, d);
      total_cnt++;
      if (q !== exp_q || q_valid !== exp_valid || updated !== exp_upd)
        $display("FAIL random[%0d] got q=%h v=%b upd=%b want q=%h v=%b upd=%b",
                 i, q, q_valid, updated, exp_q, exp_valid, exp_upd);
      else pass_cnt++;
`ifdef WRITE_REGISTER_PARITY_EN
      total_cnt++;
      if (parity_out !== ^exp_q)
        $display("FAIL random_parity[%0d] got %b want %b", i, parity_out, ^exp_q);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0;
    write = 1'b0;
    data  = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_hold();
    test_write();
    test_hold_after_write();
    test_back_to_back();
    test_parity();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
